// File: rtl/cell_gen_pkg.sv
// Shared types and sizing helpers for the cell stream generator.
// Beat count and partial last-beat width derive from cell and bus widths.
package cell_gen_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  function automatic int f_transfers(
    input int cell_bits,
    input int width
  );
    return cell_bits / width +
           (((cell_bits % width) != 0) ? 1 : 0);
  endfunction

  function automatic int f_last_bits(
    input int cell_bits,
    input int width
  );
    return ((cell_bits % width) == 0) ?
           width : (cell_bits % width);
  endfunction

endpackage

// File: rtl/cell_gen_pattern.sv
// Payload pattern register with last-beat masking and beat parity.
// Parity is built only when CELL_STREAM_GEN_PARITY_EN is defined.
module cell_gen_pattern
  import cell_gen_pkg::*;
#(
  parameter int          DAT_WIDTH = 32,
  parameter int          CELL_BITS = 424,
  parameter logic [31:0] PAY_INIT  = 32'h01020304,
  parameter logic [31:0] PAY_INC   = 32'h01010101
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 adv,
  input  logic                 clr,
  input  logic                 last,
  output logic [DAT_WIDTH-1:0] dat,
  output logic                 dat_par
);

  localparam int LAST_BITS =
    f_last_bits(CELL_BITS, DAT_WIDTH);

  localparam logic [DAT_WIDTH-1:0] INIT_W =
    DAT_WIDTH'(PAY_INIT);
  localparam logic [DAT_WIDTH-1:0] INC_W =
    DAT_WIDTH'(PAY_INC);
  localparam logic [DAT_WIDTH-1:0] LAST_MASK =
    {DAT_WIDTH{1'b1}} >> (DAT_WIDTH - LAST_BITS);

  logic [DAT_WIDTH-1:0] pat_q, pat_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;

  // pat_q tracks the unmasked pattern of the beat on the bus
  always_comb begin
    pat_d = pat_q;
    if (load) begin
      pat_d = INIT_W;
    end else if (adv) begin
      pat_d = pat_q + INC_W;
    end
    dat_d = dat_q;
    if (clr) begin
      dat_d = '0;
    end else if (load || adv) begin
      dat_d = last ? (pat_d & LAST_MASK) : pat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= INIT_W;
      dat_q <= '0;
    end else begin
      pat_q <= pat_d;
      dat_q <= dat_d;
    end
  end

  assign dat = dat_q;

`ifdef CELL_STREAM_GEN_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^dat_d;
    end
  end

  assign dat_par = par_q;
`else
  assign dat_par = 1'b0;
`endif

endmodule

// File: rtl/cell_stream_gen.sv
// ATM-style cell payload source: run FSM, beat and cell counters.
// Optional beat parity via CELL_STREAM_GEN_PARITY_EN.
module cell_stream_gen
  import cell_gen_pkg::*;
#(
  parameter int          DAT_WIDTH = 32,
  parameter int          CELL_BITS = 424,
  parameter logic [31:0] PAY_INIT  = 32'h01020304,
  parameter logic [31:0] PAY_INC   = 32'h01010101,
  parameter int          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_cells,
  input  logic                 abort,
  output logic [DAT_WIDTH-1:0] dat,
  output logic                 dat_valid,
  input  logic                 dat_ready,
  output logic                 sop,
  output logic                 eop,
  output logic                 busy,
  output logic                 done,
  output logic                 dat_par
);

  localparam int TRANSFERS =
    f_transfers(CELL_BITS, DAT_WIDTH);
  localparam int BW =
    (TRANSFERS > 1) ? $clog2(TRANSFERS) : 1;
  localparam logic [BW-1:0] LAST_BEAT =
    BW'(TRANSFERS - 1);
  localparam logic ONE_BEAT = (TRANSFERS == 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0] cell_q, cell_d;
  logic [CNT_W-1:0] ncell_q, ncell_d;
  logic             valid_q, valid_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load, adv, clr;
  logic             xfer, last_cell;

  assign xfer      = valid_q && dat_ready;
  assign last_cell = (cell_q == ncell_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cell_d  = cell_q;
    ncell_d = ncell_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    adv     = 1'b0;
    clr     = 1'b0;
    if (abort) begin
      state_d = IDLE;
      beat_d  = '0;
      cell_d  = '0;
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      busy_d  = 1'b0;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && num_cells == '0) begin
            done_d = 1'b1;
          end else if (start) begin
            state_d = SEND;
            ncell_d = num_cells;
            beat_d  = '0;
            cell_d  = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            sop_d   = 1'b1;
            eop_d   = ONE_BEAT;
            load    = 1'b1;
          end
        end
        SEND: begin
          if (xfer && eop_q && last_cell) begin
            state_d = IDLE;
            beat_d  = '0;
            cell_d  = '0;
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            clr     = 1'b1;
          end else if (xfer) begin
            adv = 1'b1;
            if (eop_q) begin
              beat_d = '0;
              cell_d = cell_q + CNT_W'(1);
            end else begin
              beat_d = beat_q + BW'(1);
            end
            sop_d = (beat_d == '0);
            eop_d = (beat_d == LAST_BEAT);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      cell_q  <= '0;
      ncell_q <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cell_q  <= cell_d;
      ncell_q <= ncell_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  cell_gen_pattern #(
    .DAT_WIDTH (DAT_WIDTH),
    .CELL_BITS (CELL_BITS),
    .PAY_INIT  (PAY_INIT),
    .PAY_INC   (PAY_INC)
  ) u_pattern (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .adv     (adv),
    .clr     (clr),
    .last    (eop_d),
    .dat     (dat),
    .dat_par (dat_par)
  );

  assign dat_valid = valid_q;
  assign sop       = sop_q;
  assign eop       = eop_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cell_stream_gen.sv
// Randomised self-checking bench for cell_stream_gen (32- and 64-bit buses).
// Expected beats come from closed-form arithmetic on the global beat index.
module tb_cell_stream_gen;

  localparam int CB = 424;
  localparam int T32 = (CB + 31) / 32;
  localparam int T64 = (CB + 63) / 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_cells = '0;
  logic        abort = 1'b0;
  logic        dat_ready = 1'b0;
  logic [31:0] dat;
  logic        dat_valid, sop, eop, busy, done, dat_par;

  logic        w_start = 1'b0;
  logic [15:0] w_num = '0;
  logic        w_abort = 1'b0;
  logic        w_ready = 1'b0;
  logic [63:0] w_dat;
  logic        w_valid, w_sop, w_eop, w_busy, w_done, w_par;

  int vec = 0;
  int errs = 0;

  logic [31:0] q_dat[$];
  bit          q_sop[$];
  bit          q_eop[$];
  bit          q_par[$];

  always #5 clk = ~clk;

  cell_stream_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_cells (num_cells),
    .abort     (abort),
    .dat       (dat),
    .dat_valid (dat_valid),
    .dat_ready (dat_ready),
    .sop       (sop),
    .eop       (eop),
    .busy      (busy),
    .done      (done),
    .dat_par   (dat_par)
  );

  cell_stream_gen #(.DAT_WIDTH(64)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .start     (w_start),
    .num_cells (w_num),
    .abort     (w_abort),
    .dat       (w_dat),
    .dat_valid (w_valid),
    .dat_ready (w_ready),
    .sop       (w_sop),
    .eop       (w_eop),
    .busy      (w_busy),
    .done      (w_done),
    .dat_par   (w_par)
  );

  // beat g of a run: INIT + g*INC modulo 2^w, upper bits cleared on a cell's last beat
  function automatic logic [63:0] exp_dat(input int g, input int w);
    int t, lb;
    logic [63:0] v;
    t  = (CB + w - 1) / w;
    lb = (CB % w == 0) ? w : CB % w;
    v  = 64'h01020304 + 64'(g) * 64'h01010101;
    if (w < 64) v = v & ((64'd1 << w) - 64'd1);
    if (g % t == t - 1 && lb < 64) v = v & ((64'd1 << lb) - 64'd1);
    return v;
  endfunction

  function automatic bit exp_par(input logic [63:0] d);
`ifdef CELL_STREAM_GEN_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  task automatic run(input int n, input int mode, input int poke,
                     output int nx, output int bad,
                     output int dn, output int lat);
    logic [31:0] pd;
    logic ps, pe, pp, pstall;
    bit poked;
    int since;
    q_dat.delete(); q_sop.delete(); q_eop.delete(); q_par.delete();
    nx = 0; bad = 0; dn = 0; lat = 0; since = 0;
    pd = '0; ps = 0; pe = 0; pp = 0; pstall = 0; poked = 0;
    start = 1'b1;
    num_cells = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) begin
        dn = 1;
        lat = since;
        break;
      end
      if (pstall && (dat !== pd || sop !== ps || eop !== pe ||
                     dat_par !== pp || dat_valid !== 1'b1)) bad++;
      start = 1'b0;
      if (poke >= 0 && !poked && nx == poke && dat_valid) begin
        start = 1'b1;
        num_cells = 16'd5;
        poked = 1;
      end
      case (mode)
        0: dat_ready = 1'b1;
        1: dat_ready = (cyc % 2 == 0);
        default: dat_ready = 1'($urandom_range(0, 1));
      endcase
      if (dat_valid && dat_ready) begin
        q_dat.push_back(dat);
        q_sop.push_back(sop);
        q_eop.push_back(eop);
        q_par.push_back(dat_par);
        nx++;
        since = 0;
      end
      pstall = dat_valid && !dat_ready;
      pd = dat; ps = sop; pe = eop; pp = dat_par;
      since++;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if ({dat, dat_valid, sop, eop, busy, done, dat_par} !== '0) begin
      errs++;
      $display("FAIL reset_out got dat=%h v=%b s=%b e=%b b=%b d=%b p=%b want all 0",
               dat, dat_valid, sop, eop, busy, done, dat_par);
    end
    vec++;
    if ({w_dat, w_valid, w_busy, w_done, w_par} !== '0) begin
      errs++;
      $display("FAIL reset_w64 got dat=%h v=%b b=%b want 0", w_dat, w_valid, w_busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_cell();
    int nx, bad, dn, lat;
    logic [63:0] e;
    run(1, 0, -1, nx, bad, dn, lat);
    vec++;
    if (nx !== T32 || dn !== 1 || lat !== 1) begin
      errs++;
      $display("FAIL single_count got n=%0d done=%0d lat=%0d want %0d 1 1", nx, dn, lat, T32);
    end
    vec++;
    if (busy !== 1'b0 || dat_valid !== 1'b0) begin
      errs++;
      $display("FAIL single_idle got busy=%b valid=%b want 0 0", busy, dat_valid);
    end
    if (nx == T32) begin
      vec++;
      if (q_dat[0] !== 32'h01020304 || q_dat[13] !== 32'h00000011) begin
        errs++;
        $display("FAIL single_ends got %h %h want 01020304 00000011", q_dat[0], q_dat[13]);
      end
    end
    for (int i = 0; i < nx; i++) begin
      e = exp_dat(i, 32);
      vec++;
      if (q_dat[i] !== e[31:0] || q_sop[i] !== (i == 0) ||
          q_eop[i] !== (i == T32 - 1) || q_par[i] !== exp_par(e)) begin
        errs++;
        $display("FAIL single_beat%0d got %h s%b e%b p%b want %h", i,
                 q_dat[i], q_sop[i], q_eop[i], q_par[i], e[31:0]);
      end
    end
  endtask

  task automatic test_stall();
    int nx, bad, dn, lat;
    logic [63:0] e;
    run(2, 1, -1, nx, bad, dn, lat);
    vec++;
    if (nx !== 2 * T32 || dn !== 1 || bad !== 0) begin
      errs++;
      $display("FAIL stall_run got n=%0d done=%0d unstable=%0d want %0d 1 0",
               nx, dn, bad, 2 * T32);
    end
    if (nx > T32) begin
      vec++;
      if (q_dat[T32] !== 32'h0F101112 || q_sop[T32] !== 1'b1) begin
        errs++;
        $display("FAIL stall_cell2 got %h sop=%b want 0F101112 1", q_dat[T32], q_sop[T32]);
      end
    end
    for (int i = 0; i < nx; i++) begin
      e = exp_dat(i, 32);
      vec++;
      if (q_dat[i] !== e[31:0] || q_sop[i] !== (i % T32 == 0) ||
          q_eop[i] !== (i % T32 == T32 - 1)) begin
        errs++;
        $display("FAIL stall_beat%0d got %h want %h", i, q_dat[i], e[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nx, bad, dn, lat;
    run(1, 0, -1, nx, bad, dn, lat);
    start = 1'b1;
    num_cells = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    vec++;
    if (dat_valid !== 1'b1 || busy !== 1'b1 || dat !== 32'h01020304 || sop !== 1'b1) begin
      errs++;
      $display("FAIL b2b_restart got v=%b b=%b dat=%h sop=%b want 1 1 01020304 1",
               dat_valid, busy, dat, sop);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic test_abort();
    int k, dn_cnt, nx, bad, dn, lat;
    start = 1'b1;
    num_cells = 16'd2;
    dat_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      if (dat_valid) k++;
      @(posedge clk); #1;
    end
    vec++;
    if (dat !== 32'h06070809 || dat_valid !== 1'b1) begin
      errs++;
      $display("FAIL abort_pre got dat=%h v=%b want 06070809 1", dat, dat_valid);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    vec++;
    if (dat_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL abort_stop got v=%b b=%b d=%b want 0 0 0", dat_valid, busy, done);
    end
    dn_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done || dat_valid) dn_cnt++;
    end
    vec++;
    if (dn_cnt !== 0) begin
      errs++;
      $display("FAIL abort_quiet got %0d active cycles want 0", dn_cnt);
    end
    start = 1'b1;
    abort = 1'b1;
    num_cells = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    vec++;
    if (dat_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL abort_wins got v=%b b=%b d=%b want 0 0 0", dat_valid, busy, done);
    end
    run(1, 0, -1, nx, bad, dn, lat);
    vec++;
    if (nx < 1 || q_dat[0] !== 32'h01020304 || q_sop[0] !== 1'b1 || dn !== 1) begin
      errs++;
      $display("FAIL abort_restart got n=%0d done=%0d want first beat 01020304", nx, dn);
    end
  endtask

  task automatic test_zero_cells();
    start = 1'b1;
    num_cells = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    vec++;
    if (done !== 1'b1 || busy !== 1'b0 || dat_valid !== 1'b0) begin
      errs++;
      $display("FAIL zero_done got d=%b b=%b v=%b want 1 0 0", done, busy, dat_valid);
    end
    @(posedge clk); #1;
    vec++;
    if (done !== 1'b0 || dat_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL zero_after got d=%b v=%b b=%b want 0 0 0", done, dat_valid, busy);
    end
  endtask

  task automatic test_start_ignored();
    int nx, bad, dn, lat;
    run(1, 0, 3, nx, bad, dn, lat);
    vec++;
    if (nx !== T32 || dn !== 1) begin
      errs++;
      $display("FAIL ignore_start got n=%0d done=%0d want %0d 1", nx, dn, T32);
    end
  endtask

  task automatic test_wide();
    logic [63:0] wq[$];
    bit ws[$], we[$], wp[$];
    logic [63:0] e;
    bit dn;
    dn = 0;
    w_start = 1'b1;
    w_num = 16'd1;
    w_ready = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (w_done) begin
        dn = 1;
        break;
      end
      if (w_valid) begin
        wq.push_back(w_dat);
        ws.push_back(w_sop);
        we.push_back(w_eop);
        wp.push_back(w_par);
      end
      @(posedge clk); #1;
    end
    vec++;
    if (wq.size() !== T64 || dn !== 1) begin
      errs++;
      $display("FAIL w64_count got %0d done=%b want %0d 1", wq.size(), dn, T64);
    end
    if (wq.size() == T64) begin
      vec++;
      if (wq[T64 - 1][63:40] !== 24'h0) begin
        errs++;
        $display("FAIL w64_mask got %h want upper 24 bits 0", wq[T64 - 1]);
      end
    end
    for (int i = 0; i < wq.size(); i++) begin
      e = exp_dat(i, 64);
      vec++;
      if (wq[i] !== e || ws[i] !== (i == 0) || we[i] !== (i == T64 - 1) ||
          wp[i] !== exp_par(e)) begin
        errs++;
        $display("FAIL w64_beat%0d got %h p%b want %h p%b", i, wq[i], wp[i], e, exp_par(e));
      end
    end
  endtask

  task automatic test_rst_midrun();
    int k;
    start = 1'b1;
    num_cells = 16'd1;
    dat_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && k < 3; c++) begin
      if (dat_valid) k++;
      @(posedge clk); #1;
    end
    dat_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    vec++;
    if ({dat, dat_valid, sop, eop, busy, done, dat_par} !== '0) begin
      errs++;
      $display("FAIL rst_mid got dat=%h v=%b b=%b d=%b want all 0", dat, dat_valid, busy, done);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int n, mode, nx, bad, dn, lat;
    logic [63:0] e;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 3);
      mode = $urandom_range(0, 2);
      run(n, mode, -1, nx, bad, dn, lat);
      vec++;
      if (nx !== n * T32 || dn !== 1 || lat !== 1 || bad !== 0) begin
        errs++;
        $display("FAIL rand%0d_run got n=%0d done=%0d lat=%0d unstable=%0d want %0d 1 1 0",
                 r, nx, dn, lat, bad, n * T32);
      end
      for (int i = 0; i < nx; i++) begin
        e = exp_dat(i, 32);
        vec++;
        if (q_dat[i] !== e[31:0] || q_sop[i] !== (i % T32 == 0) ||
            q_eop[i] !== (i % T32 == T32 - 1) || q_par[i] !== exp_par(e)) begin
          errs++;
          $display("FAIL rand%0d_beat%0d got %h want %h", r, i, q_dat[i], e[31:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_cell();
    test_stall();
    test_back_to_back();
    test_abort();
    test_zero_cells();
    test_start_ignored();
    test_wide();
    test_rst_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
